// File: rtl/tl_ram_responder.sv
// TileLink-UH manager endpoint backed by a flop-array RAM of 64-bit words.
// Accepts Get/PutFullData/PutPartialData and returns registered D beats, including multi-beat Get bursts.
module tl_ram_responder #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned MAX_LGSIZE = 6,
  parameter logic [31:0] BASE       = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_a_valid,
  output logic        io_a_ready,
  input  logic [2:0]  io_a_bits_opcode,
  input  logic [2:0]  io_a_bits_param,
  input  logic [3:0]  io_a_bits_size,
  input  logic [6:0]  io_a_bits_source,
  input  logic [31:0] io_a_bits_address,
  input  logic [7:0]  io_a_bits_mask,
  input  logic [63:0] io_a_bits_data,
  input  logic        io_a_bits_corrupt,
  input  logic        io_d_ready,
  output logic        io_d_valid,
  output logic [2:0]  io_d_bits_opcode,
  output logic [1:0]  io_d_bits_param,
  output logic [3:0]  io_d_bits_size,
  output logic [6:0]  io_d_bits_source,
  output logic        io_d_bits_sink,
  output logic        io_d_bits_denied,
  output logic [63:0] io_d_bits_data,
  output logic        io_d_bits_corrupt
);

  localparam int unsigned IW   = $clog2(DEPTH);
  localparam int unsigned BW   = (MAX_LGSIZE > 3) ? MAX_LGSIZE - 2 : 1;
  localparam logic [31:0] SPAN = 32'(8 * DEPTH);

  typedef enum logic {IDLE, BURST} state_e;

  state_e         state_q, state_d;
  logic           dv_q, dv_d;
  logic [2:0]     dop_q, dop_d;
  logic [3:0]     dsize_q, dsize_d;
  logic [6:0]     dsrc_q, dsrc_d;
  logic           dden_q, dden_d;
  logic [63:0]    ddata_q, ddata_d;
  logic           dcor_q, dcor_d;
  logic [BW-1:0]  left_q, left_d;
  logic [IW-1:0]  idx_q, idx_d;

  logic [63:0]    mem [DEPTH];

  // A-channel decode
  logic [31:0]    offset, align_mask;
  logic           is_get, is_put, in_range, aligned, size_ok, legal;
  logic [IW-1:0]  a_index, rd_idx;
  logic [3:0]     eff_size;
  logic [BW-1:0]  beats_m1;
  logic [63:0]    rd_data;
  logic           a_fire, d_fire, wr_en;

  always_comb begin
    offset     = io_a_bits_address - BASE;
    is_get     = (io_a_bits_opcode == 3'd4);
    is_put     = (io_a_bits_opcode == 3'd0) || (io_a_bits_opcode == 3'd1);
    in_range   = (io_a_bits_address >= BASE) && (offset < SPAN);
    align_mask = (32'd1 << io_a_bits_size) - 32'd1;
    aligned    = ((io_a_bits_address & align_mask) == '0);
    size_ok    = is_put ? (io_a_bits_size <= 4'd3) : (32'(io_a_bits_size) <= MAX_LGSIZE);
    legal      = (is_get || is_put) && in_range && aligned && size_ok;
    a_index    = offset[IW+2:3];
    // Denied Gets still emit a full burst, sized as if clamped to the largest legal Get
    eff_size   = (32'(io_a_bits_size) > MAX_LGSIZE) ? 4'(MAX_LGSIZE) : io_a_bits_size;
    beats_m1   = (eff_size <= 4'd3) ? '0 : BW'((32'd1 << (eff_size - 4'd3)) - 32'd1);
  end

  assign io_a_ready = reset && (state_q == IDLE) && (!dv_q || io_d_ready);
  assign a_fire     = io_a_valid && io_a_ready;
  assign d_fire     = dv_q && io_d_ready;
  assign wr_en      = a_fire && is_put && legal && !io_a_bits_corrupt;
  assign rd_idx     = (state_q == IDLE) ? a_index : idx_q;
  assign rd_data    = mem[rd_idx];

  always_ff @(posedge clock) begin
    for (int unsigned b = 0; b < 8; b++) begin
      if (wr_en && io_a_bits_mask[b]) mem[a_index][8*b +: 8] <= io_a_bits_data[8*b +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    dv_d    = dv_q;
    dop_d   = dop_q;
    dsize_d = dsize_q;
    dsrc_d  = dsrc_q;
    dden_d  = dden_q;
    ddata_d = ddata_q;
    dcor_d  = dcor_q;
    left_d  = left_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (a_fire) begin
          dv_d    = 1'b1;
          dop_d   = is_get ? 3'd1 : 3'd0;
          dsize_d = io_a_bits_size;
          dsrc_d  = io_a_bits_source;
          dden_d  = !legal;
          dcor_d  = is_get && !legal;
          ddata_d = (is_get && legal) ? rd_data : '0;
          if (is_get) begin
            left_d = beats_m1;
            idx_d  = a_index + IW'(1);
            if (beats_m1 != '0) state_d = BURST;
          end
        end else if (d_fire) begin
          dv_d = 1'b0;
        end
      end
      BURST: begin
        // Loading the last beat hands back to IDLE so a new A can fire alongside its D fire
        if (d_fire) begin
          ddata_d = dden_q ? '0 : rd_data;
          idx_d   = idx_q + IW'(1);
          left_d  = left_q - BW'(1);
          if (left_q == BW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dv_q    <= 1'b0;
      dop_q   <= '0;
      dsize_q <= '0;
      dsrc_q  <= '0;
      dden_q  <= 1'b0;
      ddata_q <= '0;
      dcor_q  <= 1'b0;
      left_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      dv_q    <= dv_d;
      dop_q   <= dop_d;
      dsize_q <= dsize_d;
      dsrc_q  <= dsrc_d;
      dden_q  <= dden_d;
      ddata_q <= ddata_d;
      dcor_q  <= dcor_d;
      left_q  <= left_d;
      idx_q   <= idx_d;
    end
  end

  assign io_d_valid        = dv_q;
  assign io_d_bits_opcode  = dop_q;
  assign io_d_bits_param   = '0;
  assign io_d_bits_size    = dsize_q;
  assign io_d_bits_source  = dsrc_q;
  assign io_d_bits_sink    = 1'b0;
  assign io_d_bits_denied  = dden_q;
  assign io_d_bits_data    = ddata_q;
  assign io_d_bits_corrupt = dcor_q;

  logic unused_a_param;
  assign unused_a_param = ^io_a_bits_param;

endmodule
